// File: rtl/fifo_out_tx_pkg.sv
// Shared types and sizing helpers for the fifo_out transmit buffer.
// Optional build macro: FIFO_OUT_TX_STATS_EN (stall counter).
package fifo_out_tx_pkg;

    localparam int DATA_W    = 16;
    localparam int DEPTH_DEF = 8;

    typedef logic [DATA_W-1:0] data_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_out_tx_mem.sv
// Register-array storage for fifo_out_tx.
// One write port, one asynchronous read port, no reset.
module fifo_out_tx_mem
    import fifo_out_tx_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = ptr_w(DEPTH) - 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_out_tx.sv
// Transmit end of the fifo_out valid/ready interface: DEPTH-entry circular buffer.
// Define FIFO_OUT_TX_STATS_EN to add the saturating stall_cnt output.
module fifo_out_tx
    import fifo_out_tx_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     data_in_vld,
    output logic                     data_in_rdy,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_out_vld,
    input  logic                     data_out_rdy,
    output logic [ptr_w(DEPTH)-1:0]  level
`ifdef FIFO_OUT_TX_STATS_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // MSB is the wrap flag; low bits address the array
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign data_in_rdy  = !full;
    assign data_out_vld = !empty;
    assign level        = wr_ptr - rd_ptr;

    assign push = data_in_vld && !full;
    assign pop  = !empty && data_out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    fifo_out_tx_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (data_out)
    );

`ifdef FIFO_OUT_TX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (data_out_vld && !data_out_rdy && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_out_tx.sv
// Self-checking bench for fifo_out_tx: directed tables, corner sequences,
// random traffic against a queue model, and a valid/data hold monitor.
module tb_fifo_out_tx;
    import fifo_out_tx_pkg::*;

    localparam int DEPTH = 8;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] data_in;
    logic              data_in_vld;
    logic              data_in_rdy;
    logic [DATA_W-1:0] data_out;
    logic              data_out_vld;
    logic              data_out_rdy;
    logic [3:0]        level;
`ifdef FIFO_OUT_TX_STATS_EN
    logic [31:0]       stall_cnt;
`endif

    fifo_out_tx #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_in_vld  (data_in_vld),
        .data_in_rdy  (data_in_rdy),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .data_out_rdy (data_out_rdy),
        .level        (level)
`ifdef FIFO_OUT_TX_STATS_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] q[$];
    longint      stall_exp = 0;

    typedef struct {
        logic        vld;
        logic [15:0] din;
        logic        rdy;
        logic        e_in_rdy;
        logic        e_out_vld;
        int          e_level;
        logic [15:0] e_dout;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".in_rdy"}, 32'(data_in_rdy), 32'(q.size() < DEPTH));
        chk({tag, ".out_vld"}, 32'(data_out_vld), 32'(q.size() != 0));
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        if (q.size() != 0) chk({tag, ".dout"}, 32'(data_out), 32'(q[0]));
`ifdef FIFO_OUT_TX_STATS_EN
        chk({tag, ".stall"}, stall_cnt, 32'(stall_exp));
`endif
    endtask

    task automatic model_edge(input logic vld, input logic [15:0] din,
                              input logic rdy);
        bit do_pop;
        bit do_push;
        do_pop  = (q.size() != 0) && rdy;
        do_push = vld && (q.size() < DEPTH);
        if (q.size() != 0 && !rdy && stall_exp < 64'hFFFF_FFFF) stall_exp++;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(din);
    endtask

    task automatic cycle(input logic vld, input logic [15:0] din,
                         input logic rdy, input string tag);
        data_in_vld  = vld;
        data_in      = din;
        data_out_rdy = rdy;
        #1;
        model_check(tag);
        model_edge(vld, din, rdy);
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1; reset is asserted and released off-edge
    task automatic do_reset();
        data_in_vld  = 1'b0;
        data_in      = '0;
        data_out_rdy = 1'b0;
        #2 rst_n = 1'b0;
        q.delete();
        stall_exp = 0;
        #1;
        chk("rst.out_vld", 32'(data_out_vld), 32'd0);
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.in_rdy", 32'(data_in_rdy), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Valid must hold, with stable data, until popped
    int          rst_ev = 0;
    int          rst_ev_prev = 0;
    logic        hold_pend = 1'b0;
    logic [15:0] hold_data = '0;

    always @(negedge rst_n) rst_ev++;

    always @(negedge clk) begin
        if (rst_n && hold_pend && rst_ev == rst_ev_prev) begin
            chk("hold.vld", 32'(data_out_vld), 32'd1);
            chk("hold.data", 32'(data_out), 32'(hold_data));
        end
        hold_pend   = rst_n && data_out_vld && !data_out_rdy;
        hold_data   = data_out;
        rst_ev_prev = rst_ev;
    end

    initial begin
        rst_n        = 1'b0;
        data_in      = '0;
        data_in_vld  = 1'b0;
        data_out_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("init.out_vld", 32'(data_out_vld), 32'd0);
        chk("init.level", 32'(level), 32'd0);
        chk("init.in_rdy", 32'(data_in_rdy), 32'd1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Push 1..3 with ready high: one-cycle latency, back-to-back pops
        vt[0] = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 0, 16'h0000};
        vt[1] = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 1, 16'h0001};
        vt[2] = '{1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 1, 16'h0002};
        vt[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1, 16'h0003};
        vt[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            data_in_vld  = vt[i].vld;
            data_in      = vt[i].din;
            data_out_rdy = vt[i].rdy;
            #1;
            chk($sformatf("tbl%0d.in_rdy", i), 32'(data_in_rdy), 32'(vt[i].e_in_rdy));
            chk($sformatf("tbl%0d.out_vld", i), 32'(data_out_vld), 32'(vt[i].e_out_vld));
            chk($sformatf("tbl%0d.level", i), 32'(level), 32'(vt[i].e_level));
            if (vt[i].e_out_vld)
                chk($sformatf("tbl%0d.dout", i), 32'(data_out), 32'(vt[i].e_dout));
            model_edge(vt[i].vld, vt[i].din, vt[i].rdy);
            @(posedge clk);
            #1;
        end

        // Fill to DEPTH, reject a 9th word, then drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0, "fill");
        chk("full.level", 32'(level), 32'd8);
        chk("full.in_rdy", 32'(data_in_rdy), 32'd0);
        cycle(1'b1, 16'hDEAD, 1'b0, "ninth");
        chk("ninth.level", 32'(level), 32'd8);
        cycle(1'b0, 16'h0000, 1'b1, "drain");
        chk("drain.rdy_back", 32'(data_in_rdy), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            chk("drain.order", 32'(data_out), 32'(16'hA000 + 16'(i)));
            cycle(1'b0, 16'h0000, 1'b1, "drain");
        end
        chk("drain.empty", 32'(data_out_vld), 32'd0);

        // Steady state at level 4 across pointer wrap
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0, "pre4");
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 16'hC004 + 16'(i), 1'b1, "lvl4");
            chk("lvl4.level", 32'(level), 32'd4);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, "post4");

        // Five-cycle stall on 0xBEEF
        do_reset();
        cycle(1'b1, 16'hBEEF, 1'b0, "beef");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'h0000, 1'b0, "stall");
            chk("stall.dout", 32'(data_out), 32'h0000_BEEF);
        end
`ifdef FIFO_OUT_TX_STATS_EN
        chk("stall.cnt5", stall_cnt, 32'd5);
`endif
        cycle(1'b0, 16'h0000, 1'b1, "unstall");

        // Asynchronous reset mid-burst at level 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h5000 + 16'(i), 1'b0, "burst");
        chk("burst.level", 32'(level), 32'd5);
        data_in_vld = 1'b1;
        data_in     = 16'h5005;
        do_reset();
        cycle(1'b1, 16'h1234, 1'b0, "post_rst");
        chk("post_rst.first", 32'(data_out), 32'h0000_1234);
        cycle(1'b1, 16'h5678, 1'b1, "post_rst");
        cycle(1'b0, 16'h0000, 1'b1, "post_rst");
        cycle(1'b0, 16'h0000, 1'b1, "post_rst");

        // Random traffic with phase-varying ready bias to hit full and empty
        for (int i = 0; i < 10000; i++) begin
            int  ph;
            logic v;
            logic r;
            ph = (i / 500) % 4;
            v  = ($urandom_range(0, 3) != 0);
            case (ph)
                0:       r = ($urandom_range(0, 3) == 0);
                1:       r = ($urandom_range(0, 3) != 0);
                2:       r = 1'b1;
                default: r = $urandom_range(0, 1) != 0;
            endcase
            cycle(v, 16'($urandom), r, "rnd");
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 16'h0000, 1'b1, "flush");
        chk("end.empty", 32'(data_out_vld), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_out_tx.md
# fifo_out_tx

Transmit end of the FIFO output valid/ready interface: buffers 16-bit words from an upstream valid/ready source and drives `data_out`/`data_out_vld` toward a downstream consumer that returns `data_out_rdy`. It is the producer-side counterpart of the `fifo_out` agent's driver, which only samples data and valid and drives ready. It sits at the FIFO read port in the DUT and absorbs downstream backpressure with a DEPTH-entry circular buffer.

## Interface
- DEPTH, 8, number of buffer entries; power of two, ≥ 2
- DATA_W, 16, word width; fixed at 16 for the `fifo_out` interface
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  DATA_W  upstream word
- data_in_vld  in  1  upstream word valid
- data_in_rdy  out  1  block can accept a word this cycle
- data_out  out  DATA_W  word presented downstream
- data_out_vld  out  1  `data_out` holds a valid word
- data_out_rdy  in  1  downstream accepts the word
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- stall_cnt  out  32  present only with FIFO_OUT_TX_STATS_EN; see Configuration

## Operation
- Push: a word is written when `data_in_vld && data_in_rdy` is high at the posedge. It goes to `mem[wr_ptr]`, and `wr_ptr` increments.
- Pop: a word is removed when `data_out_vld && data_out_rdy` is high at the posedge, and `rd_ptr` increments.
- Pointers are $clog2(DEPTH)+1 bits wide. The MSB is the wrap flag and the low bits index `mem`.
  - empty: pointers are fully equal.
  - full: low bits are equal and the MSBs differ.
- `level = wr_ptr - rd_ptr` (modulo arithmetic, same width as the pointers).
- `data_in_rdy = !full`, decoded from registered pointers only, with no combinational path from `data_out_rdy`.
- `data_out_vld = !empty`.
- `data_out = mem[rd_ptr[low]]`. When empty it holds the last value and the consumer ignores it.
- Push while full: `data_in_rdy` is already low, so the write is not accepted even if a pop happens in the same cycle. There is no full-bypass.
- Push and pop in the same cycle when neither empty nor full: both take effect and `level` is unchanged.
- Push while empty: `data_out_vld` rises the next cycle. There is no same-cycle flow-through.
- Protocol guarantee: once `data_out_vld` is high it stays high, with `data_out` stable, until a pop occurs.
- Reset (asserted at any time, including mid-transfer):
  - pointers clear to 0 and all buffered words are discarded
  - `data_out_vld=0`, `data_in_rdy=1`, `level=0`, `stall_cnt=0`
  - `data_out` is X/don't-care; `mem` is not reset.

## Timing
- Latency from push accept to `data_out_vld` is 1 cycle when empty.
- Sustained throughput is 1 word/cycle with `data_out_rdy` held high.
- `data_in_rdy` re-asserts the cycle after a pop from full.
- `level` updates at the same posedge as the push/pop it reflects.
- Every output is a register or a decode of registers. There is no input-to-output combinational path.

## Configuration
- FIFO_OUT_TX_STATS_EN defined: adds the `stall_cnt` port.
  - Increments on every posedge where `data_out_vld && !data_out_rdy`.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset.
- FIFO_OUT_TX_STATS_EN undefined: the port and counter logic are absent, and all other behaviour is identical.

## Structure
- `fifo_out_tx_pkg` holds:
  - `localparam DATA_W = 16`
  - `typedef logic [DATA_W-1:0] data_t`
  - default DEPTH constant
  - pointer-width helper function
- `fifo_out_tx_mem` is a sub-module for the register-array storage: one write port, one asynchronous read port, no reset.
- The top level holds the pointers, flags, level, and the optional stall counter.

## Test plan
- Reset, then push 0x0001..0x0003 with `data_out_rdy=1` → `data_out_vld` rises 1 cycle after the first push, and 0x0001, 0x0002, 0x0003 pop on consecutive cycles.
- Hold `data_out_rdy=0` and push DEPTH=8 words → `level=8`, `data_in_rdy=0`, and a 9th word offered is not accepted. Raise ready → 8 words drain in order and `data_in_rdy=1` one cycle after the first pop.
- At `level=4`, push and pop every cycle for 20 cycles → `level` stays 4, ordering is preserved, and pointer wrap-around is exercised.
- Stall with valid high, `data_out=0xBEEF`, `data_out_rdy=0` for 5 cycles → `data_out` stays 0xBEEF and `data_out_vld` stays 1. With FIFO_OUT_TX_STATS_EN, `stall_cnt=5`.
- Assert `rst_n=0` asynchronously mid-burst at `level=5` → `data_out_vld` and `level` drop to 0 immediately and `data_in_rdy=1`. After release, the first new push pops first.
- Random `data_in_vld`/`data_out_rdy` for 10k cycles → scoreboard shows no loss, duplication, or reordering, and neither the valid-hold nor the stable-data assertion fires.
